// File: rtl/huffman_category.sv
// -----------------------------------------------------------------------------
// huffman_category
//
// Purpose:
//   Computes the JPEG magnitude category (SSSS) of a signed 12-bit coefficient
//   or DC difference, together with the matching "additional bits" field.
//   The category is available combinationally, so the Huffman ROM can be
//   addressed in the same cycle. A registered copy of the category and the
//   additional bits is also provided. That copy is qualified by q_valid for
//   downstream pipeline stages.
//
// Ports:
//   clk_in    in   1   clock, rising edge
//   rst       in   1   asynchronous, active-high reset
//   d_in      in  12   signed two's-complement input value
//   d_valid   in   1   capture d_in into the output registers this cycle
//   category  out  4   combinational category of d_in (0..12)
//   cat_q     out  4   registered category
//   bits_q    out 12   registered additional bits, right-justified
//   q_valid   out  1   cat_q/bits_q hold a result captured one edge earlier
// -----------------------------------------------------------------------------
module huffman_category (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [11:0] d_in,
  input  logic        d_valid,
  output logic [3:0]  category,
  output logic [3:0]  cat_q,
  output logic [11:0] bits_q,
  output logic        q_valid
);

  // ---------------------------------------------------------------------------
  // Magnitude.
  // The value is sign-extended to 13 bits before it is negated. This lets
  // -2048 become +2048 (bit 11 set), which naturally yields category 12.
  // ---------------------------------------------------------------------------
  logic        is_neg;
  logic [12:0] d_ext;
  logic [12:0] mag;

  assign is_neg = d_in[11];
  assign d_ext  = {d_in[11], d_in};
  assign mag    = is_neg ? (13'd0 - d_ext) : d_ext;

  // ---------------------------------------------------------------------------
  // Leading-one detection.
  // lead[gi] is set only for the highest set bit of mag. At most one lead bit
  // is ever active, and none are active when mag is zero.
  // ---------------------------------------------------------------------------
  logic [12:0] lead;

  genvar gi;
  generate
    for (gi = 0; gi < 13; gi = gi + 1) begin : g_lead
      assign lead[gi] = mag[gi] & ~(|(mag >> (gi + 1)));
    end
  endgenerate

  // The category is the position of the leading one plus 1.
  // A zero magnitude falls through to the default of 0, so the output is
  // never X for a known input.
  logic [3:0] cat_next;

  always_comb begin
    cat_next = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (lead[i]) begin
        cat_next = 4'(i + 1);
      end
    end
  end

  assign category = cat_next;

  // ---------------------------------------------------------------------------
  // Additional bits.
  // Negative values use (v - 1) mod 4096, which is the one's complement of
  // |v|. For -2048 this wraps to 0x7FF. The raw value is then masked down to
  // the low 'category' bits. A category of 0 masks everything to zero.
  // ---------------------------------------------------------------------------
  logic [11:0] bits_raw;
  logic [11:0] bits_mask;
  logic [11:0] bits_next;

  assign bits_raw = is_neg ? (d_in - 12'd1) : d_in;

  generate
    for (gi = 0; gi < 12; gi = gi + 1) begin : g_mask
      assign bits_mask[gi] = (cat_next > 4'(gi));
    end
  endgenerate

  assign bits_next = bits_raw & bits_mask;

  // ---------------------------------------------------------------------------
  // Output register stage.
  // q_valid tracks d_valid with one cycle of latency. The data registers are
  // loaded only on valid cycles; on idle cycles they keep the last result.
  // ---------------------------------------------------------------------------
  logic [3:0]  cat_reg;
  logic [11:0] bits_reg;
  logic        valid_reg;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cat_reg   <= 4'd0;
      bits_reg  <= 12'd0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= d_valid;
      if (d_valid) begin
        cat_reg  <= cat_next;
        bits_reg <= bits_next;
      end
    end
  end

  assign cat_q   = cat_reg;
  assign bits_q  = bits_reg;
  assign q_valid = valid_reg;

endmodule

// File: tb/tb_huffman_category.sv
// -----------------------------------------------------------------------------
// tb_huffman_category
//
// Purpose:
//   Self-checking bench for huffman_category. It compares the DUT against a
//   reference model computed arithmetically from the category and
//   additional-bits definitions.
//
// Stimulus:
//   - directed values
//   - an exhaustive sweep of all input values
//   - valid gating
//   - an asynchronous reset
//   - randomized traffic
// -----------------------------------------------------------------------------
module tb_huffman_category;

  logic        clk_in;
  logic        rst;
  logic [11:0] d_in;
  logic        d_valid;
  logic [3:0]  category;
  logic [3:0]  cat_q;
  logic [11:0] bits_q;
  logic        q_valid;

  int checks = 0;
  int errors = 0;

  // Expected registered state, maintained by the model.
  int exp_cat  = 0;
  int exp_bits = 0;
  int exp_qv   = 0;

  huffman_category dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .d_in     (d_in),
    .d_valid  (d_valid),
    .category (category),
    .cat_q    (cat_q),
    .bits_q   (bits_q),
    .q_valid  (q_valid)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Watchdog: guarantees the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------

  // Interpret a 12-bit pattern as a signed integer.
  function automatic int to_signed(input logic [11:0] d);
    logic signed [11:0] s;
    s = d;
    return int'(s);
  endfunction

  // Category: the smallest n with |v| < 2^n, and 0 for v = 0.
  function automatic int ref_cat(input logic [11:0] d);
    int v;
    int a;
    int n;
    v = to_signed(d);
    if (v == 0) return 0;
    a = (v < 0) ? -v : v;
    n = 0;
    while ((1 << n) <= a) n++;
    return n;
  endfunction

  // Additional bits: v, or (v - 1) mod 4096, reduced to the low n bits.
  function automatic int ref_bits(input logic [11:0] d);
    int v;
    int n;
    int raw;
    v = to_signed(d);
    n = ref_cat(d);
    if (n == 0) return 0;
    raw = (v >= 0) ? v : (((v - 1) % 4096) + 4096) % 4096;
    return raw % (1 << n);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, obs, obs, expv, expv);
    end
  endtask

  // Entry phase: just after a rising edge.
  // Drives one cycle of input and checks the combinational category. It then
  // crosses the next rising edge and checks the registered outputs.
  task automatic apply(input logic [11:0] d, input logic v);
    d_in    = d;
    d_valid = v;
    #1;
    chk("category", int'(category), ref_cat(d));
    @(posedge clk_in);
    if (v) begin
      exp_cat  = ref_cat(d);
      exp_bits = ref_bits(d);
    end
    exp_qv = v ? 1 : 0;
    #1;
    chk("cat_q", int'(cat_q), exp_cat);
    chk("bits_q", int'(bits_q), exp_bits);
    chk("q_valid", int'(q_valid), exp_qv);
  endtask

  // Directed value: also checks against the hand-derived constants.
  task automatic dir(input logic [11:0] d, input int c, input int b);
    apply(d, 1'b1);
    chk("dir_cat", int'(cat_q), c);
    chk("dir_bits", int'(bits_q), b);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    d_in    = 12'h000;
    d_valid = 1'b0;
    #1;
    chk("reset_cat_q", int'(cat_q), 0);
    chk("reset_bits_q", int'(bits_q), 0);
    chk("reset_q_valid", int'(q_valid), 0);

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    @(posedge clk_in);
    #1;
    chk("post_release_q_valid", int'(q_valid), 0);

    // Zero and unit values
    dir(12'h000, 0, 12'h000);
    dir(12'h001, 1, 12'h001);
    dir(12'hFFF, 1, 12'h000);

    // Small magnitudes
    dir(12'h005, 3, 12'h005);
    dir(12'hFFB, 3, 12'h002);
    dir(12'h004, 3, 12'h004);
    dir(12'hFFC, 3, 12'h003);

    // Extremes
    dir(12'h7FF, 11, 12'h7FF);
    dir(12'h400, 11, 12'h400);
    dir(12'hC00, 11, 12'h3FF);
    dir(12'h800, 12, 12'h7FF);

    // Valid gating: 1,0,1
    dir(12'h003, 2, 12'h003);
    apply(12'h7FF, 1'b0);
    chk("gate_idle_category", int'(category), 11);
    chk("gate_idle_q_valid", int'(q_valid), 0);
    chk("gate_hold_cat", int'(cat_q), 2);
    chk("gate_hold_bits", int'(bits_q), 12'h003);
    dir(12'hFFE, 2, 12'h001);

    // Exhaustive sweep with d_valid held high
    for (int i = 0; i < 4096; i++) begin
      apply(12'(i), 1'b1);
    end

    // Asynchronous reset mid-stream
    dir(12'h010, 5, 12'h010);
    chk("pre_reset_q_valid", int'(q_valid), 1);
    d_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cat_q", int'(cat_q), 0);
    chk("async_rst_bits_q", int'(bits_q), 0);
    chk("async_rst_q_valid", int'(q_valid), 0);
    exp_cat  = 0;
    exp_bits = 0;
    exp_qv   = 0;
    @(negedge clk_in);
    rst = 1'b0;
    @(posedge clk_in);
    #1;
    chk("rst_release_q_valid", int'(q_valid), 0);
    dir(12'h010, 5, 12'h010);

    // Randomized traffic with random valid gating
    for (int i = 0; i < 400; i++) begin
      apply(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
